data_consuming_block: RTL and testbench
=======================================

DATA_CONSUMING_BLOCK -- requirements
Module: data_consuming_block

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, giving the input FIFO depth; the value SHALL be a power of two and at least 2.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 The module SHALL have port valid_in, input, 1 bit, upstream data valid.
REQ-005 The module SHALL have port ready_out, output, 1 bit, this block can accept a byte.
REQ-006 The module SHALL have port data_in, input, 8 bits, upstream byte.
REQ-007 The module SHALL have port throttle, input, 2 bits, drain rate: 00 every cycle, 01 every 2nd cycle, 10 every 4th cycle, 11 halted.
REQ-008 The module SHALL have port frame_len, input, 8 bits, bytes per frame; value 0 means 256.
REQ-009 The module SHALL have port frame_done, output, 1 bit, one-cycle pulse marking frame completion.
REQ-010 The module SHALL have port frame_sum, output, 16 bits, modulo-2^16 sum of the last completed frame.
REQ-011 The module SHALL have port frame_xor, output, 8 bits, XOR of all bytes of the last completed frame.
REQ-012 The module SHALL have port frame_cnt, output, 16 bits, count of completed frames, wrapping at 2^16.

Function
REQ-013 A byte SHALL be accepted (pushed) in any cycle where valid_in and ready_out are both 1; otherwise nothing is pushed.
REQ-014 ready_out SHALL equal 1 exactly when the FIFO is not full; it depends only on registered occupancy, never on valid_in.
REQ-015 A pushed byte SHALL be eligible for pop no earlier than the following cycle.
REQ-016 A free-running 2-bit tick counter SHALL increment every cycle.
REQ-017 Pop SHALL occur when all of: FIFO not empty; state is not REPORT; throttle allows it.
REQ-018 Throttle allows pop as follows: 00 always; 01 when tick[0]=0; 10 when tick=00; 11 never.
REQ-019 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH.
REQ-021 The FSM SHALL have states IDLE, ACCUM and REPORT.
REQ-022 IDLE, on pop: SHALL sample frame_len into the remaining counter (0 maps to 256), load the accumulators with the popped byte, then go to ACCUM or, if the frame length is 1, to REPORT.
REQ-023 ACCUM, on pop: SHALL add the byte to the sum (modulo 2^16), XOR it into the xor accumulator and decrement the remaining count; on the final byte of the frame it SHALL go to REPORT.
REQ-024 REPORT, for exactly one cycle: SHALL assert frame_done, update frame_sum, frame_xor and frame_cnt (incremented by 1) in that same cycle, then go to IDLE.
REQ-025 frame_sum, frame_xor and frame_cnt SHALL hold their values between REPORT cycles.
REQ-026 frame_done SHALL assert in the cycle immediately after the final pop of a frame.
REQ-027 frame_len changes mid-frame SHALL have no effect until the next IDLE pop.
REQ-028 Pushes SHALL continue during REPORT while the FIFO is not full.

Reset
REQ-029 Assertion of rst (low) SHALL immediately clear FIFO occupancy and pointers, tick, accumulators, state (to IDLE), frame_done, frame_sum, frame_xor and frame_cnt to 0.
REQ-030 During reset, ready_out SHALL be 1.
REQ-031 A frame in progress at reset SHALL be discarded without a frame_done pulse.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration and the throttle encoding constants.
REQ-033 The FIFO SHALL be a separate sub-module named sync_fifo, parameterised by DEPTH and width 8.

Verification
REQ-034 With throttle=00 and frame_len=4, streaming bytes 01,02,03,04 SHALL produce one frame_done pulse with frame_sum=0x000A, frame_xor=0x04, frame_cnt=1.
REQ-035 With throttle=11 and valid_in held high, exactly 4 bytes SHALL be accepted, ready_out SHALL then stay 0, and setting throttle=00 SHALL restore ready_out=1 the cycle after the first pop.
REQ-036 With frame_len=0 and 256 bytes of 0xFF, the result SHALL be frame_sum=0xFF00, frame_xor=0x00, with exactly one frame_done.
REQ-037 With throttle=10 and the FIFO kept non-empty, pops SHALL occur exactly every 4th cycle, when tick=00.
REQ-038 Asserting rst after 2 of 4 bytes SHALL clear all outputs to 0 with no frame_done; a following 4-byte frame 05,05,05,05 SHALL then give frame_sum=0x0014, frame_xor=0x00, frame_cnt=1.
REQ-039 Back-to-back frames with frame_len=1 SHALL give alternating pop/REPORT cycles and frame_cnt incrementing by 1 per byte.

Source files
------------

// File: rtl/data_consuming_block_pkg.sv
// Shared definitions for the data consuming block: FSM states and the
// throttle encodings that set how often the FIFO is drained.
package data_consuming_block_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [1:0] THR_EVERY   = 2'b00;
    localparam logic [1:0] THR_HALF    = 2'b01;
    localparam logic [1:0] THR_QUARTER = 2'b10;
    localparam logic [1:0] THR_HALT    = 2'b11;

    // Decide whether the current tick phase permits a pop for a throttle setting.
    function automatic logic pop_allowed(input logic [1:0] throttle, input logic [1:0] tick);
        logic ok;
        ok = 1'b0;
        case (throttle)
            THR_EVERY:   ok = 1'b1;
            THR_HALF:    ok = (tick[0] == 1'b0);
            THR_QUARTER: ok = (tick == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered occupancy. Read data is presented
// combinationally from the read pointer, so a byte written on one edge can be
// popped no earlier than the following cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array needs no reset; only written on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; occupancy is unchanged by push+pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_consuming_block.sv
// Consumes a byte stream through a small FIFO, drains it at a throttled rate
// and reports a 16-bit sum, an XOR and a running count for each frame.
module data_consuming_block
    import data_consuming_block_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [7:0]  data_in,
    input  logic [1:0]  throttle,
    input  logic [7:0]  frame_len,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic [7:0]  frame_xor,
    output logic [15:0] frame_cnt
);

    state_t      state;
    state_t      next_state;
    logic        full;
    logic        empty;
    logic [7:0]  fifo_data;
    logic        push;
    logic        pop;
    logic [1:0]  tick;
    logic [8:0]  remaining;
    logic [8:0]  len_eff;
    logic        last_byte;
    logic [15:0] acc_sum;
    logic [7:0]  acc_xor;
    logic [15:0] next_sum;
    logic [7:0]  next_xor;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_data (data_in),
        .rd_data (fifo_data),
        .full    (full),
        .empty   (empty)
    );

    assign ready_out  = !full;
    assign push       = valid_in && ready_out;
    assign pop        = !empty && (state != REPORT) && pop_allowed(throttle, tick);
    assign frame_done = (state == REPORT);

    // A frame length of zero stands for a 256-byte frame.
    assign len_eff   = (frame_len == 8'd0) ? 9'd256 : {1'b0, frame_len};
    assign last_byte = (state == IDLE) ? (len_eff == 9'd1) : (remaining == 9'd1);

    // The first byte of a frame restarts the accumulators; later bytes add into them.
    always_comb begin
        next_sum = acc_sum + {8'h00, fifo_data};
        next_xor = acc_xor ^ fifo_data;
        if (state == IDLE) begin
            next_sum = {8'h00, fifo_data};
            next_xor = fifo_data;
        end
    end

    // Free-running phase counter used by the throttle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick <= 2'd0;
        end else begin
            tick <= tick + 2'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a frame ends on its last pop and REPORT always lasts one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    next_state = last_byte ? REPORT : ACCUM;
                end
            end
            ACCUM: begin
                if (pop && last_byte) begin
                    next_state = REPORT;
                end
            end
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Accumulators and remaining-byte count; frame_len is only sampled on the first pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remaining <= 9'd0;
            acc_sum   <= 16'd0;
            acc_xor   <= 8'd0;
        end else if (pop) begin
            acc_sum <= next_sum;
            acc_xor <= next_xor;
            if (state == IDLE) begin
                remaining <= len_eff - 9'd1;
            end else begin
                remaining <= remaining - 9'd1;
            end
        end
    end

    // Results load on the final pop so they are already valid while frame_done is high, then hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_sum <= 16'd0;
            frame_xor <= 8'd0;
            frame_cnt <= 16'd0;
        end else if (pop && last_byte) begin
            frame_sum <= next_sum;
            frame_xor <= next_xor;
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_data_consuming_block.sv
// Scoreboard bench for data_consuming_block: stimulus queues the expected
// frame results, a monitor compares them whenever frame_done pulses.
module tb_data_consuming_block;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  data_in;
    logic [1:0]  throttle;
    logic [7:0]  frame_len;
    logic        frame_done;
    logic [15:0] frame_sum;
    logic [7:0]  frame_xor;
    logic [15:0] frame_cnt;

    typedef struct {
        logic [15:0] sum;
        logic [7:0]  xr;
        logic [15:0] cnt;
        int          phase;
        int          gap;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_exp;
    int         checks;
    int         errors;
    int         cyc;
    int         last_done_cyc;
    logic [1:0] tb_tick;

    data_consuming_block #(
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_in    (data_in),
        .throttle   (throttle),
        .frame_len  (frame_len),
        .frame_done (frame_done),
        .frame_sum  (frame_sum),
        .frame_xor  (frame_xor),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter for measuring spacing between frame_done pulses.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference tick phase: cleared by reset, advancing once per cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_tick <= 2'd0;
        else      tb_tick <= tb_tick + 2'd1;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_frame(input logic [15:0] s, input logic [7:0] x, input logic [15:0] c,
                                input int ph, input int gp);
        exp_t e;
        e.sum   = s;
        e.xr    = x;
        e.cnt   = c;
        e.phase = ph;
        e.gap   = gp;
        exp_q.push_back(e);
    endtask

    // Offer one byte at a negedge and hold it until the block accepts it.
    task automatic apply_stimulus(input logic [7:0] b);
        int guard;
        guard    = 0;
        valid_in = 1'b1;
        data_in  = b;
        while (ready_out !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (ready_out !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: ready_out=%b, expected 1 within 200 cycles", ready_out);
            valid_in = 1'b0;
        end else begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: %0d frames outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Monitor: every frame_done pulse must match the oldest queued expectation.
    initial last_done_cyc = -1;
    always @(negedge clk) begin
        if (rst === 1'b1 && frame_done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_frame_done: got frame_done=1 at cycle %0d, expected 0", cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("frame_sum", frame_sum, mon_exp.sum);
                check_output("frame_xor", frame_xor, mon_exp.xr);
                check_output("frame_cnt", frame_cnt, mon_exp.cnt);
                if (mon_exp.phase >= 0) check_output("done_tick_phase", tb_tick, mon_exp.phase);
                if (mon_exp.gap >= 0)   check_output("done_gap", cyc - last_done_cyc, mon_exp.gap);
            end
            last_done_cyc = cyc;
        end
    end

    // Safety net in case the run stalls entirely.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  accepted;
        logic took;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        valid_in  = 1'b0;
        data_in   = 8'h00;
        throttle  = 2'b00;
        frame_len = 8'd4;
        repeat (3) @(negedge clk);

        // Reset state
        check_output("reset_ready_out", ready_out, 1);
        check_output("reset_frame_done", frame_done, 0);
        check_output("reset_frame_sum", frame_sum, 0);
        check_output("reset_frame_xor", frame_xor, 0);
        check_output("reset_frame_cnt", frame_cnt, 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic 4-byte frame; frame_len change mid-frame must be ignored
        $display("[TB] basic frame");
        expect_frame(16'h000A, 8'h04, 16'd1, -1, -1);
        apply_stimulus(8'h01);
        apply_stimulus(8'h02);
        frame_len = 8'd2;
        apply_stimulus(8'h03);
        apply_stimulus(8'h04);
        frame_len = 8'd4;
        wait_drain("basic_frame", 50);

        // Halted drain fills the FIFO, then release
        $display("[TB] halt and release");
        expect_frame(16'h00A0, 8'h40, 16'd2, -1, -1);
        throttle = 2'b11;
        accepted = 0;
        data_in  = 8'h10;
        valid_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            took = ready_out;
            @(negedge clk);
            if (took) begin
                accepted++;
                data_in = data_in + 8'h10;
            end
        end
        valid_in = 1'b0;
        check_output("halt_accepted", accepted, 4);
        check_output("halt_ready_low", ready_out, 0);
        repeat (3) @(negedge clk);
        check_output("halt_ready_still_low", ready_out, 0);
        throttle = 2'b00;
        check_output("ready_in_first_pop_cycle", ready_out, 0);
        @(negedge clk);
        check_output("ready_after_first_pop", ready_out, 1);
        wait_drain("halt_release", 50);

        // 256-byte frame of 0xFF
        $display("[TB] 256-byte frame");
        frame_len = 8'd0;
        expect_frame(16'hFF00, 8'h00, 16'd3, -1, -1);
        for (int i = 0; i < 256; i++) apply_stimulus(8'hFF);
        wait_drain("long_frame", 100);
        frame_len = 8'd4;

        // Quarter-rate drain: one-byte frames, done one cycle after tick==00
        $display("[TB] quarter-rate throttle");
        throttle  = 2'b10;
        frame_len = 8'd1;
        expect_frame(16'h0011, 8'h11, 16'd4, 1, -1);
        expect_frame(16'h0022, 8'h22, 16'd5, 1, 4);
        expect_frame(16'h0033, 8'h33, 16'd6, 1, 4);
        expect_frame(16'h0044, 8'h44, 16'd7, 1, 4);
        apply_stimulus(8'h11);
        apply_stimulus(8'h22);
        apply_stimulus(8'h33);
        apply_stimulus(8'h44);
        wait_drain("quarter_rate", 100);

        // Reset mid-frame discards the partial frame
        $display("[TB] reset mid-frame");
        throttle  = 2'b00;
        frame_len = 8'd4;
        apply_stimulus(8'h01);
        apply_stimulus(8'h02);
        rst = 1'b0;
        #1;
        check_output("midreset_ready_out", ready_out, 1);
        check_output("midreset_frame_done", frame_done, 0);
        check_output("midreset_frame_sum", frame_sum, 0);
        check_output("midreset_frame_xor", frame_xor, 0);
        check_output("midreset_frame_cnt", frame_cnt, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_frame(16'h0014, 8'h00, 16'd1, -1, -1);
        for (int i = 0; i < 4; i++) apply_stimulus(8'h05);
        wait_drain("after_reset", 50);

        // Back-to-back one-byte frames alternate pop and REPORT
        $display("[TB] back-to-back single-byte frames");
        frame_len = 8'd1;
        expect_frame(16'h00A1, 8'hA1, 16'd2, -1, -1);
        expect_frame(16'h00B2, 8'hB2, 16'd3, -1, 2);
        expect_frame(16'h00C3, 8'hC3, 16'd4, -1, 2);
        apply_stimulus(8'hA1);
        apply_stimulus(8'hB2);
        apply_stimulus(8'hC3);
        wait_drain("single_byte", 50);

        repeat (10) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
